load_align_unit: RTL and testbench

Parametrised load-data path between the core's memory stage and the data bus. It accepts one load request at a time and issues one or two aligned bus reads, splitting the access when it crosses a bus-word boundary. It then shifts, masks and sign/zero-extends the returned data and presents one register-ready result to writeback. It supersedes the purely combinational load-mask stage: it generalises XLEN to 32/64 and adds byte-offset alignment, misaligned split handling and a fault path.

---
 rtl/load_align_unit.sv | 175 +++++++++++++++++
 tb/tb_load_align_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load-data path between the memory stage and the data bus: issues one or two
// aligned bus reads per load, then shifts, masks and extends the result.
module load_align_unit #(
    parameter int XLEN               = 32,
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,

    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [31:0]     bus_req_addr,
    input  logic            bus_rsp_valid,
    input  logic [XLEN-1:0] bus_rsp_data,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFS_W = $clog2(BYTES);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE0 = 3'd1;
    localparam logic [2:0] ST_WAIT0  = 3'd2;
    localparam logic [2:0] ST_ISSUE1 = 3'd3;
    localparam logic [2:0] ST_WAIT1  = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    logic [2:0]       state_q,    state_d;
    logic [OFS_W-1:0] ofs_q,      ofs_d;
    logic [1:0]       size_q,     size_d;
    logic             uns_q,      uns_d;
    logic             cross_q,    cross_d;
    logic [XLEN-1:0]  beat0_q,    beat0_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
    logic             fault_q,    fault_d;

    logic [OFS_W-1:0] req_ofs;
    logic [4:0]       req_end;
    logic             req_cross;
    logic             req_illegal;
    logic             req_fault;

    // Shift the two-beat window down to the addressed byte, keep 1<<size
    // bytes and extend. Full-width loads leave ~mask empty, so they pass through.
    function automatic logic [XLEN-1:0] form_result(
        input logic [XLEN-1:0]  b1,
        input logic [XLEN-1:0]  b0,
        input logic [OFS_W-1:0] ofs,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] mask;
        logic            sign;
        int              nb;
        lo = XLEN'({b1, b0} >> {ofs, 3'b000});
        nb = 8 << size;
        if (nb > XLEN) nb = XLEN;
        mask = {XLEN{1'b1}} >> (XLEN - nb);
        sign = |(lo & mask & ~(mask >> 1));
        form_result = lo & mask;
        if (!uns && sign) form_result = form_result | ~mask;
    endfunction

    assign req_ofs     = req_addr[OFS_W-1:0];
    assign req_end     = 5'(req_ofs) + (5'd1 << req_size);
    assign req_cross   = req_end > 5'(BYTES);
    assign req_illegal = (req_size == 2'd3) && (XLEN == 32);
    assign req_fault   = req_illegal || (req_cross && (SUPPORT_MISALIGNED == 0));

    always_comb begin
        state_d    = state_q;
        ofs_d      = ofs_q;
        size_d     = size_q;
        uns_d      = uns_q;
        cross_d    = cross_q;
        beat0_d    = beat0_q;
        bus_addr_d = bus_addr_q;
        rsp_data_d = rsp_data_q;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ofs_d      = req_ofs;
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    cross_d    = req_cross;
                    beat0_d    = '0;
                    rsp_data_d = '0;
                    if (req_fault) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        fault_d    = 1'b0;
                        bus_addr_d = {req_addr[31:OFS_W], {OFS_W{1'b0}}};
                        state_d    = ST_ISSUE0;
                    end
                end
            end
            ST_ISSUE0: begin
                if (bus_req_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (bus_rsp_valid) begin
                    beat0_d = bus_rsp_data;
                    if (cross_q) begin
                        // 32-bit add wraps past the top of the address space
                        bus_addr_d = bus_addr_q + 32'(BYTES);
                        state_d    = ST_ISSUE1;
                    end else begin
                        rsp_data_d = form_result('0, bus_rsp_data, ofs_q, size_q, uns_q);
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ISSUE1: begin
                if (bus_req_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (bus_rsp_valid) begin
                    rsp_data_d = form_result(bus_rsp_data, beat0_q, ofs_q, size_q, uns_q);
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ofs_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            cross_q    <= 1'b0;
            beat0_q    <= '0;
            bus_addr_q <= '0;
            rsp_data_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ofs_q      <= ofs_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            cross_q    <= cross_d;
            beat0_q    <= beat0_d;
            bus_addr_q <= bus_addr_d;
            rsp_data_q <= rsp_data_d;
            fault_q    <= fault_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign bus_req_valid = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
    assign bus_req_addr  = bus_addr_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_fault     = fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit split-capable, 32-bit faulting
// and 64-bit instances driven from one stimulus set, observed through a selector.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        bus_req_ready;
    logic        bus_rsp_valid;
    logic [31:0] bd32;
    logic [63:0] bd64;
    logic        rsp_ready;

    logic        o0_req_ready, o0_bus_req_valid, o0_rsp_valid, o0_rsp_fault;
    logic [31:0] o0_bus_req_addr, o0_rsp_data;
    logic        o1_req_ready, o1_bus_req_valid, o1_rsp_valid, o1_rsp_fault;
    logic [31:0] o1_bus_req_addr, o1_rsp_data;
    logic        o2_req_ready, o2_bus_req_valid, o2_rsp_valid, o2_rsp_fault;
    logic [31:0] o2_bus_req_addr;
    logic [63:0] o2_rsp_data;

    int          sel;
    logic        m_req_ready, m_bus_req_valid, m_rsp_valid, m_rsp_fault;
    logic [31:0] m_bus_req_addr;
    logic [63:0] m_rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .SUPPORT_MISALIGNED(1)) u32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(o0_req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .bus_req_valid(o0_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(o0_bus_req_addr), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bd32),
        .rsp_valid(o0_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o0_rsp_data),
        .rsp_fault(o0_rsp_fault)
    );

    load_align_unit #(.XLEN(32), .SUPPORT_MISALIGNED(0)) u32f (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(o1_req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .bus_req_valid(o1_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(o1_bus_req_addr), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bd32),
        .rsp_valid(o1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o1_rsp_data),
        .rsp_fault(o1_rsp_fault)
    );

    load_align_unit #(.XLEN(64), .SUPPORT_MISALIGNED(1)) u64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(o2_req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .bus_req_valid(o2_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(o2_bus_req_addr), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bd64),
        .rsp_valid(o2_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o2_rsp_data),
        .rsp_fault(o2_rsp_fault)
    );

    always_comb begin
        m_req_ready     = o0_req_ready;
        m_bus_req_valid = o0_bus_req_valid;
        m_bus_req_addr  = o0_bus_req_addr;
        m_rsp_valid     = o0_rsp_valid;
        m_rsp_data      = {32'h0, o0_rsp_data};
        m_rsp_fault     = o0_rsp_fault;
        case (sel)
            1: begin
                m_req_ready     = o1_req_ready;
                m_bus_req_valid = o1_bus_req_valid;
                m_bus_req_addr  = o1_bus_req_addr;
                m_rsp_valid     = o1_rsp_valid;
                m_rsp_data      = {32'h0, o1_rsp_data};
                m_rsp_fault     = o1_rsp_fault;
            end
            2: begin
                m_req_ready     = o2_req_ready;
                m_bus_req_valid = o2_bus_req_valid;
                m_bus_req_addr  = o2_bus_req_addr;
                m_rsp_valid     = o2_rsp_valid;
                m_rsp_data      = o2_rsp_data;
                m_rsp_fault     = o2_rsp_fault;
            end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        int          exp_nreq;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        rsp_ready     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        pend;
        logic [63:0] beat;
        do_reset();
        sel  = v.sel;
        lat  = -1;
        nreq = 0;
        a0   = '0;
        a1   = '0;
        pend = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_req_ready", idx), 64'(m_req_ready), 64'd1);
        req_valid    = 1'b1;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            bus_rsp_valid = pend;
            beat          = (nreq == 1) ? v.b0 : v.b1;
            bd32          = beat[31:0];
            bd64          = beat;
            pend          = 1'b0;
            if (m_rsp_valid) begin
                lat = c;
            end else if (m_bus_req_valid) begin
                if (nreq == 0) a0 = m_bus_req_addr;
                else           a1 = m_bus_req_addr;
                nreq++;
                pend = bus_req_ready;
            end
        end
        bus_rsp_valid = 1'b0;
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d_nreq", idx), 64'(nreq), 64'(v.exp_nreq));
        if (v.exp_nreq >= 1) check($sformatf("v%0d_addr0", idx), 64'(a0), 64'(v.exp_a0));
        if (v.exp_nreq >= 2) check($sformatf("v%0d_addr1", idx), 64'(a1), 64'(v.exp_a1));
        check($sformatf("v%0d_data", idx), m_rsp_data, v.exp_data);
        check($sformatf("v%0d_fault", idx), 64'(m_rsp_fault), 64'(v.exp_fault));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_valid_drop", idx), 64'(m_rsp_valid), 64'd0);
        check($sformatf("v%0d_ready_again", idx), 64'(m_req_ready), 64'd1);
    endtask

    int results;

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_size      = '0;
        req_unsigned  = 1'b0;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        bd32          = '0;
        bd64          = '0;
        rsp_ready     = 1'b0;
        sel           = 0;

        //        sel addr          sz    uns   beat0                  beat1                  expected data          flt   lat nreq addr0          addr1
        vt[0]  = '{0, 32'h0000_1003, 2'd0, 1'b0, 64'h80AABBCC,          64'h0,                 64'hFFFFFF80,          1'b0, 3, 1, 32'h0000_1000, 32'h0};
        vt[1]  = '{0, 32'h0000_1002, 2'd1, 1'b1, 64'hBEEF1234,          64'h0,                 64'h0000BEEF,          1'b0, 3, 1, 32'h0000_1000, 32'h0};
        vt[2]  = '{0, 32'h0000_1002, 2'd1, 1'b0, 64'hBEEF1234,          64'h0,                 64'hFFFFBEEF,          1'b0, 3, 1, 32'h0000_1000, 32'h0};
        vt[3]  = '{0, 32'h0000_1001, 2'd2, 1'b0, 64'h44332211,          64'h88776655,          64'h55443322,          1'b0, 5, 2, 32'h0000_1000, 32'h0000_1004};
        vt[4]  = '{0, 32'h0000_2000, 2'd0, 1'b1, 64'h000000F0,          64'h0,                 64'h000000F0,          1'b0, 3, 1, 32'h0000_2000, 32'h0};
        vt[5]  = '{0, 32'h0000_2004, 2'd2, 1'b0, 64'hDEADBEEF,          64'h0,                 64'hDEADBEEF,          1'b0, 3, 1, 32'h0000_2004, 32'h0};
        vt[6]  = '{0, 32'h0000_3003, 2'd1, 1'b0, 64'h12000000,          64'h000000A5,          64'hFFFFA512,          1'b0, 5, 2, 32'h0000_3000, 32'h0000_3004};
        vt[7]  = '{0, 32'h0000_4000, 2'd3, 1'b0, 64'h0,                 64'h0,                 64'h0,                 1'b1, 1, 0, 32'h0,         32'h0};
        vt[8]  = '{1, 32'h0000_1003, 2'd1, 1'b0, 64'h0,                 64'h0,                 64'h0,                 1'b1, 1, 0, 32'h0,         32'h0};
        vt[9]  = '{1, 32'h0000_1000, 2'd2, 1'b0, 64'h11223344,          64'h0,                 64'h11223344,          1'b0, 3, 1, 32'h0000_1000, 32'h0};
        vt[10] = '{2, 32'hFFFF_FFFC, 2'd3, 1'b0, 64'h8877665544332211,  64'h00FFEEDDCCBBAA99,  64'hCCBBAA9988776655,  1'b0, 5, 2, 32'hFFFF_FFF8, 32'h0000_0000};
        vt[11] = '{2, 32'h0000_2004, 2'd2, 1'b0, 64'h89ABCDEF01234567,  64'h0,                 64'hFFFFFFFF89ABCDEF,  1'b0, 3, 1, 32'h0000_2000, 32'h0};
        vt[12] = '{2, 32'h0000_2006, 2'd2, 1'b1, 64'hAAAABBBBCCCCDDDD,  64'h0000000000003344,  64'h000000003344AAAA,  1'b0, 5, 2, 32'h0000_2000, 32'h0000_2008};
        vt[13] = '{2, 32'h0000_2007, 2'd0, 1'b0, 64'h7F00000000000000,  64'h0,                 64'h000000000000007F,  1'b0, 3, 1, 32'h0000_2000, 32'h0};

        // Reset values
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d_req_ready", s), 64'(m_req_ready), 64'd1);
            check($sformatf("rst%0d_bus_req_valid", s), 64'(m_bus_req_valid), 64'd0);
            check($sformatf("rst%0d_bus_req_addr", s), 64'(m_bus_req_addr), 64'd0);
            check($sformatf("rst%0d_rsp_valid", s), 64'(m_rsp_valid), 64'd0);
            check($sformatf("rst%0d_rsp_data", s), m_rsp_data, 64'd0);
            check($sformatf("rst%0d_rsp_fault", s), 64'(m_rsp_fault), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Backpressure on request, response and writeback sides
        do_reset();
        sel     = 0;
        results = 0;
        @(negedge clk);
        req_valid     = 1'b1;
        req_addr      = 32'h0000_1002;
        req_size      = 2'd1;
        req_unsigned  = 1'b1;
        bus_req_ready = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            bus_req_ready = (c == 3);
            bus_rsp_valid = (c == 7) || (c == 9);
            bd32          = (c == 7) ? 32'hBEEF1234 : 32'h55555555;
            rsp_ready     = (c == 12);
            if (c <= 3) begin
                check($sformatf("bp_c%0d_bus_valid", c), 64'(m_bus_req_valid), 64'd1);
                check($sformatf("bp_c%0d_bus_addr", c), 64'(m_bus_req_addr), 64'h1000);
            end
            if (c <= 12) check($sformatf("bp_c%0d_req_ready", c), 64'(m_req_ready), 64'd0);
            if (c >= 4 && c <= 7) begin
                check($sformatf("bp_c%0d_bus_idle", c), 64'(m_bus_req_valid), 64'd0);
                check($sformatf("bp_c%0d_no_rsp", c), 64'(m_rsp_valid), 64'd0);
            end
            if (c >= 8 && c <= 12) begin
                check($sformatf("bp_c%0d_rsp_valid", c), 64'(m_rsp_valid), 64'd1);
                check($sformatf("bp_c%0d_rsp_data", c), m_rsp_data, 64'h0000BEEF);
            end
            if (c == 13) check("bp_ready_after", 64'(m_req_ready), 64'd1);
            if (m_rsp_valid && rsp_ready) results++;
        end
        bus_rsp_valid = 1'b0;
        check("bp_result_count", 64'(results), 64'd1);

        // Reset while waiting for the second beat; late response must be dropped
        do_reset();
        sel = 0;
        @(negedge clk);
        req_valid     = 1'b1;
        req_addr      = 32'h0000_1001;
        req_size      = 2'd2;
        req_unsigned  = 1'b0;
        bus_req_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        bd32          = 32'h44332211;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        check("rw_issue1_valid", 64'(m_bus_req_valid), 64'd1);
        check("rw_issue1_addr", 64'(m_bus_req_addr), 64'h1004);
        @(negedge clk);
        check("rw_wait1_busy", 64'(m_req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rw_async_idle", 64'(m_req_ready), 64'd1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus_rsp_valid = 1'b1;
        bd32          = 32'h88776655;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_rsp_valid = 1'b0;
            check($sformatf("rw_c%0d_no_rsp", c), 64'(m_rsp_valid), 64'd0);
            check($sformatf("rw_c%0d_req_ready", c), 64'(m_req_ready), 64'd1);
            check($sformatf("rw_c%0d_bus_idle", c), 64'(m_bus_req_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
